qsys_system_dmem_arbiter: RTL and testbench

QSYS_SYSTEM_DMEM_ARBITER -- requirements
Module: qsys_system_dmem_arbiter

---
 rtl/qsys_system_dmem_pkg.sv | 16 +
 rtl/qsys_system_dmem_rr_arb.sv | 58 +++++
 rtl/qsys_system_dmem_arbiter.sv | 120 ++++++++++++
 tb/tb_qsys_system_dmem_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/qsys_system_dmem_pkg.sv
// Shared constants and types for the two-master data-memory arbiter.
package qsys_system_dmem_pkg;

  localparam int DEPTH_DEFAULT = 8000;
  localparam int ADDR_W        = 13;
  localparam int DATA_W        = 32;
  localparam int BE_W          = 4;

  localparam logic [DATA_W-1:0] BAD_DATA = 32'hDEADBEEF;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } mid_t;

endpackage

// File: rtl/qsys_system_dmem_rr_arb.sv
// Round-robin grant between two masters with a burst limit; combinational grant, zero latency.
// A master holding the bus may keep it for MAX_BURST grants while the other waits, then must yield.
module qsys_system_dmem_rr_arb
  import qsys_system_dmem_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic       gnt_vld,
  output mid_t       gnt_id
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  mid_t             last_grant;
  logic [CNT_W-1:0] burst_cnt;
  mid_t             other;
  logic             last_req;
  logic             other_req;

  assign other     = (last_grant == M0) ? M1 : M0;
  assign last_req  = (last_grant == M0) ? req[0] : req[1];
  assign other_req = (last_grant == M0) ? req[1] : req[0];

  // burst_cnt == 0 means no run in progress, so plain round-robin decides.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = last_grant;
    if (!reset && (|req)) begin
      gnt_vld = 1'b1;
      if (last_req && (burst_cnt != '0) && ((burst_cnt < CNT_MAX) || !other_req))
        gnt_id = last_grant;
      else if (other_req)
        gnt_id = other;
      else
        gnt_id = last_grant;
    end
  end

  // A switch restarts the run at the new owner's first grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= M1;
      burst_cnt  <= '0;
    end else if (!gnt_vld) begin
      burst_cnt  <= '0;
    end else if (gnt_id != last_grant) begin
      last_grant <= gnt_id;
      burst_cnt  <= CNT_W'(1);
    end else if (burst_cnt != CNT_MAX) begin
      burst_cnt  <= burst_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/qsys_system_dmem_arbiter.sv
// Two-master arbiter for a single-port data RAM; same-cycle grant, read data returns 1 cycle later.
// Losing master sees waitrequest. Optional out-of-range trap: DMEM_ARB_RANGE_CHECK_EN.
module qsys_system_dmem_arbiter
  import qsys_system_dmem_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEFAULT,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              err_flag
);

  logic [1:0]  req;
  logic        gnt_vld;
  mid_t        gnt_id;
  logic        sel_wr;
  logic        bad;
  logic        rd_vld;
  mid_t        rd_id;
  logic        rd_bad;
  logic [DATA_W-1:0] ret_data;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  qsys_system_dmem_rr_arb #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    sel_wr         = 1'b0;
    if (gnt_vld) begin
      if (gnt_id == M0) begin
        mem_address    = m0_address;
        mem_byteenable = m0_byteenable;
        mem_writedata  = m0_writedata;
        sel_wr         = m0_write;
      end else begin
        mem_address    = m1_address;
        mem_byteenable = m1_byteenable;
        mem_writedata  = m1_writedata;
        sel_wr         = m1_write;
      end
    end
  end

`ifdef DMEM_ARB_RANGE_CHECK_EN
  assign bad = gnt_vld && (int'(mem_address) >= DEPTH);

  always_ff @(posedge clk) begin
    if (reset)
      err_flag <= 1'b0;
    else if (bad)
      err_flag <= 1'b1;
  end
`else
  logic unused_depth;
  assign unused_depth = ^DEPTH;
  assign bad          = 1'b0;
  assign err_flag     = 1'b0;
`endif

  // Out-of-range accesses are accepted but never reach the RAM.
  assign mem_chipselect = gnt_vld && !bad;
  assign mem_write      = gnt_vld && sel_wr && !bad;
  assign mem_clken      = !reset;

  assign m0_waitrequest = !reset && req[0] && !(gnt_vld && gnt_id == M0);
  assign m1_waitrequest = !reset && req[1] && !(gnt_vld && gnt_id == M1);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld <= 1'b0;
      rd_id  <= M0;
      rd_bad <= 1'b0;
    end else begin
      rd_vld <= gnt_vld && !sel_wr;
      rd_id  <= gnt_id;
      rd_bad <= bad;
    end
  end

  // Gating with reset drops a read that was in flight when reset arrived.
  assign ret_data         = rd_bad ? BAD_DATA : mem_readdata;
  assign m0_readdatavalid = !reset && rd_vld && (rd_id == M0);
  assign m1_readdatavalid = !reset && rd_vld && (rd_id == M1);
  assign m0_readdata      = m0_readdatavalid ? ret_data : '0;
  assign m1_readdata      = m1_readdatavalid ? ret_data : '0;

endmodule

// File: tb/tb_qsys_system_dmem_arbiter.sv
// Directed bench for the data-memory arbiter with a behavioural byte-enabled 1-cycle RAM.
module tb_qsys_system_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_readdata = 32'h0;
  logic        err_flag;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] ram [0:8191];

  always #5 clk = ~clk;

  qsys_system_dmem_arbiter #(.DEPTH(8000), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .err_flag(err_flag)
  );

  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = 4'hF; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = 4'hF; m1_writedata = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_wait0"}, m0_waitrequest, 0);
    check({tag, "_wait1"}, m1_waitrequest, 0);
    check({tag, "_rdv0"}, m0_readdatavalid, 0);
    check({tag, "_rdv1"}, m1_readdatavalid, 0);
    check({tag, "_rd0"}, m0_readdata, 0);
    check({tag, "_rd1"}, m1_readdata, 0);
    check({tag, "_cs"}, mem_chipselect, 0);
    check({tag, "_clken"}, mem_clken, 0);
    check({tag, "_err"}, err_flag, 0);
  endtask

  initial begin
    int g, pg;
    for (int i = 0; i < 8192; i++) ram[i] = 32'h1000_0000 | 32'(i);
    idle();
    reset = 1;

    // Reset with both masters requesting: everything quiet.
    m0_read = 1; m0_address = 13'd1;
    m1_read = 1; m1_address = 13'd2;
    step(); step();
    #4;
    check_reset_state("rst");

    // Both masters read every cycle: 4 grants each, data one cycle later.
    step();
    reset = 0;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) step();
      #4;
      g = (k / 4) % 2;
      check("burst_wait0", m0_waitrequest, (g == 1));
      check("burst_wait1", m1_waitrequest, (g == 0));
      check("burst_addr", mem_address, (g == 1) ? 32'd2 : 32'd1);
      if (k > 0) begin
        pg = ((k - 1) / 4) % 2;
        check("burst_rdv0", m0_readdatavalid, (pg == 0));
        check("burst_rdv1", m1_readdatavalid, (pg == 1));
        check("burst_rd0", m0_readdata, (pg == 0) ? 32'h1000_0001 : 32'h0);
        check("burst_rd1", m1_readdata, (pg == 1) ? 32'h1000_0002 : 32'h0);
      end else begin
        check("burst_rdv0_first", m0_readdatavalid, 0);
        check("burst_rdv1_first", m1_readdatavalid, 0);
      end
    end
    step();
    idle();
    #4;
    check("burst_tail_rdv0", m0_readdatavalid, 1);
    check("burst_tail_rd0", m0_readdata, 32'h1000_0001);
    check("idle_cs", mem_chipselect, 0);
    check("idle_addr", mem_address, 0);
    check("idle_be", mem_byteenable, 0);
    check("idle_wait0", m0_waitrequest, 0);

    // m1 alone: partial write then read back.
    step();
    m1_write = 1; m1_address = 13'd5; m1_writedata = 32'hA5A5A5A5; m1_byteenable = 4'b0011;
    #4;
    check("wr_wait1", m1_waitrequest, 0);
    check("wr_cs", mem_chipselect, 1);
    check("wr_we", mem_write, 1);
    check("wr_addr", mem_address, 5);
    check("wr_be", mem_byteenable, 4'b0011);
    check("wr_data", mem_writedata, 32'hA5A5A5A5);
    step();
    m1_write = 0; m1_read = 1; m1_byteenable = 4'hF;
    #4;
    check("rdb_wait1", m1_waitrequest, 0);
    check("rdb_we", mem_write, 0);
    check("wr_no_rdv1", m1_readdatavalid, 0);
    step();
    idle();
    #4;
    check("rdb_rdv1", m1_readdatavalid, 1);
    check("rdb_rd1", m1_readdata, 32'h1000_A5A5);
    check("rdb_rdv0", m0_readdatavalid, 0);

    // m0 granted last, then m0 read and m1 write collide: m1 wins.
    step();
    m0_read = 1; m0_address = 13'd3;
    #4;
    check("col_pre_wait0", m0_waitrequest, 0);
    step();
    idle();
    #4;
    check("col_pre_rd0", m0_readdata, 32'h1000_0003);
    step();
    m0_read = 1; m0_address = 13'd3;
    m1_write = 1; m1_address = 13'd6; m1_writedata = 32'h1234_5678;
    #4;
    check("col_wait0", m0_waitrequest, 1);
    check("col_wait1", m1_waitrequest, 0);
    check("col_we", mem_write, 1);
    check("col_addr", mem_address, 6);
    step();
    m1_write = 0; m1_address = '0;
    #4;
    check("col_retry_wait0", m0_waitrequest, 0);
    check("col_retry_addr", mem_address, 3);
    check("col_wr_no_rdv1", m1_readdatavalid, 0);
    check("col_wr_no_rdv0", m0_readdatavalid, 0);
    step();
    idle();
    #4;
    check("col_rdv0", m0_readdatavalid, 1);
    check("col_rd0", m0_readdata, 32'h1000_0003);

    // Reset the cycle after a read issues: the read is dropped.
    step();
    m0_read = 1; m0_address = 13'd4;
    #4;
    check("midrst_issue_cs", mem_chipselect, 1);
    step();
    reset = 1;
    #4;
    check_reset_state("midrst");
    step();
    reset = 0;
    idle();
    #4;
    check("postrst_rdv0", m0_readdatavalid, 0);
    check("postrst_rdv1", m1_readdatavalid, 0);

    // Out-of-range address 8000.
    step();
    m0_read = 1; m0_address = 13'd8000;
    #4;
    check("oor_wait0", m0_waitrequest, 0);
`ifdef DMEM_ARB_RANGE_CHECK_EN
    check("oor_cs", mem_chipselect, 0);
`else
    check("oor_cs", mem_chipselect, 1);
`endif
    step();
    idle();
    #4;
    check("oor_rdv0", m0_readdatavalid, 1);
`ifdef DMEM_ARB_RANGE_CHECK_EN
    check("oor_rd0", m0_readdata, 32'hDEADBEEF);
    check("oor_err", err_flag, 1);
`else
    check("oor_rd0", m0_readdata, 32'h1000_1F40);
    check("oor_err", err_flag, 0);
`endif
    step();
    #4;
`ifdef DMEM_ARB_RANGE_CHECK_EN
    check("oor_err_sticky", err_flag, 1);
`else
    check("oor_err_sticky", err_flag, 0);
`endif
    step();
    reset = 1;
    step();
    reset = 0;
    #4;
    check("oor_err_cleared", err_flag, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
